uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/hack_io_pkg.sv | 22 ++
 rtl/uart_rx_fifo_mem.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped UART receiver: FSM states,
// STATUS register bit positions and register-select addresses.
package hack_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_VALID   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVR     = 2;
  localparam int STAT_FERR    = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 4;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte FIFO for the UART receiver: storage, wrapping pointers and a separate
// occupancy count. The caller guarantees wr_en only when not full or popping.
module uart_rx_fifo_mem #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and DATA/STATUS registers on the
// Hack memory map. Define UART_RX_FERR_EN to drop frames whose stop bit is low.
module uart_rx_fifo
  import hack_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic        i_Serial_RX,
  input  logic        i_ADDR,
  input  logic        i_RD,
  output logic [15:0] o_RDATA,
  output logic        o_RX_VALID
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  logic              rx_p0;
  logic              rx_p1;
  rx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_byte;
  logic              push_req;
  logic              frame_bad;
  logic              push;
  logic              pop;
  logic              set_ovr;
  logic              clr_flags;
  logic              ovr_flag;
  logic              ferr_flag;
  logic [7:0]        head;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [15:0]       status;
`ifdef UART_RX_FERR_EN
  logic              stop_bit;
`endif

  // Stage p0/p1: bring the asynchronous line into the clock domain.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_Serial_RX;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      push_req <= 1'b0;
`ifdef UART_RX_FERR_EN
      stop_bit <= 1'b1;
`endif
    end else begin
      push_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_p1) state <= ST_START;
        end
        ST_START: begin
          // Mid-start-bit check: a line already back high was only a glitch.
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            push_req <= 1'b1;
`ifdef UART_RX_FERR_EN
            stop_bit <= rx_p1;
`endif
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (state == ST_DATA && baud_cnt == BIT_LAST) rx_byte <= {rx_p1, rx_byte[7:1]};
  end

`ifdef UART_RX_FERR_EN
  assign frame_bad = ~stop_bit;
`else
  assign frame_bad = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop       = i_RD & (i_ADDR == ADDR_DATA) & ~empty;
  assign push      = push_req & ~frame_bad & (~full | pop);
  assign set_ovr   = push_req & ~frame_bad & full & ~pop;
  assign clr_flags = i_RD & (i_ADDR == ADDR_STATUS);

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      ovr_flag  <= 1'b0;
      ferr_flag <= 1'b0;
    end else begin
      ovr_flag  <= set_ovr | (ovr_flag & ~clr_flags);
      ferr_flag <= (push_req & frame_bad) | (ferr_flag & ~clr_flags);
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (i_CLK),
    .rst_n   (i_RESET_n),
    .wr_en   (push),
    .wr_data (rx_byte),
    .rd_en   (pop),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    status = '0;
    status[STAT_VALID] = ~empty;
    status[STAT_FULL]  = full;
    status[STAT_OVR]   = ovr_flag;
    status[STAT_FERR]  = ferr_flag;
    status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count);
  end

  assign o_RDATA    = (i_ADDR == ADDR_STATUS) ? status
                    : (empty ? 16'h0000 : {8'h00, head});
  assign o_RX_VALID = ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4; accepted
// bytes are queued when sent and compared on DATA reads.
module tb_uart_rx_fifo;
  import hack_io_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic        addr  = 1'b0;
  logic        rd    = 1'b0;
  logic [15:0] rdata;
  logic        rx_valid;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  q[$];
  int          cyc = 0;
  int          rise_cyc = -1;
  int          last_start = 0;
  logic        valid_q = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_CLK       (clk),
    .i_RESET_n   (rst_n),
    .i_Serial_RX (rx),
    .i_ADDR      (addr),
    .i_RD        (rd),
    .o_RDATA     (rdata),
    .o_RX_VALID  (rx_valid)
  );

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    valid_q <= rx_valid;
    if (rx_valid && !valid_q) rise_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    rx = 1'b0;
    last_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rd_reg(input logic a, output logic [15:0] v);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic chk_data(input string tag);
    logic [15:0] v;
    logic [15:0] exp;
    exp = (q.size() > 0) ? {8'h00, q.pop_front()} : 16'h0000;
    rd_reg(ADDR_DATA, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic chk_status(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    rd_reg(ADDR_STATUS, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  fill [4];
    logic        found;

    // Reset state
    repeat (3) @(negedge clk);
    addr = ADDR_STATUS;
    #1 check("rst_status", 32'(rdata), 32'h0);
    addr = ADDR_DATA;
    #1 check("rst_data", 32'(rdata), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, latency and drain
    send_byte(8'h41, 1'b1);
    q.push_back(8'h41);
    check("latency_ok", 32'((rise_cyc > last_start) && (rise_cyc - last_start <= 10 * CPB + 3)), 32'h1);
    check("valid_after_rx", 32'(rx_valid), 32'h1);
    chk_data("rd_41");
    check("valid_after_rd", 32'(rx_valid), 32'h0);
    chk_data("rd_empty");

    // Short low glitch on idle line
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
    check("glitch_valid", 32'(rx_valid), 32'h0);
    chk_status("glitch_status", 16'h0000);

    // Overrun: five bytes into a four-entry FIFO
    fill = '{8'h41, 8'h42, 8'h0D, 8'h55};
    for (int i = 0; i < 4; i++) begin
      send_byte(fill[i], 1'b1);
      q.push_back(fill[i]);
    end
    send_byte(8'h66, 1'b1);
    chk_status("ovr_status", 16'h0040 | 16'h0004 | 16'h0002 | 16'h0001);
    chk_status("ovr_cleared", 16'h0040 | 16'h0002 | 16'h0001);
    for (int i = 0; i < 4; i++) chk_data($sformatf("ovr_rd%0d", i));
    chk_status("ovr_drained", 16'h0000);

    // Pop coinciding with push into a full FIFO
    fill = '{8'h41, 8'h42, 8'h55, 8'h66};
    for (int i = 0; i < 4; i++) begin
      send_byte(fill[i], 1'b1);
      q.push_back(fill[i]);
    end
    found = 1'b0;
    fork
      send_byte(8'h0D, 1'b1);
      begin
        for (int i = 0; i < 12 * CPB; i++) begin
          @(negedge clk);
          if (dut.push_req) begin
            found = 1'b1;
            break;
          end
        end
        check("push_seen", 32'(found), 32'h1);
        if (found) begin
          addr = ADDR_DATA;
          rd   = 1'b1;
          #1 v = rdata;
          check("pop_on_push", 32'(v), 32'({8'h00, q.pop_front()}));
          @(negedge clk);
          rd = 1'b0;
        end
      end
    join
    q.push_back(8'h0D);
    chk_status("simul_status", 16'h0040 | 16'h0002 | 16'h0001);
    for (int i = 0; i < 4; i++) chk_data($sformatf("simul_rd%0d", i));

    // Stop bit low
    send_byte(8'h42, 1'b0);
`ifdef UART_RX_FERR_EN
    chk_status("ferr_status", 16'h0008);
    chk_status("ferr_cleared", 16'h0000);
`else
    q.push_back(8'h42);
    chk_status("noferr_status", 16'h0011);
    chk_data("noferr_rd42");
`endif

    // Reset in the middle of a frame with a byte already queued
    send_byte(8'h55, 1'b1);
    q.push_back(8'h55);
    check("pre_rst_valid", 32'(rx_valid), 32'h1);
    fork
      send_byte(8'h41, 1'b1);
      begin
        repeat (4 * CPB + 8) @(negedge clk);
        rst_n = 1'b0;
        addr  = ADDR_STATUS;
        #1 check("midrst_status", 32'(rdata), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
      end
    join
    q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_status("post_rst_status", 16'h0000);
    send_byte(8'h42, 1'b1);
    q.push_back(8'h42);
    chk_data("post_rst_rd42");
    chk_status("final_status", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
